// File: rtl/shifter_pkg.sv
// Shared constants for the registered shifter family (left, right, rotate).
package shifter_pkg;

    // FSM state encoding shared across the shifter blocks
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Shift fill mode
    localparam logic SH_LOGICAL = 1'b0;
    localparam logic SH_ARITH   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } shift_state_e;

endpackage

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: one bit position per clock, logical or
// arithmetic fill, with last-out and sticky bits for rounding logic.
module seq_right_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] I,
    input  logic [SHW-1:0]   Shift,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] X,
    output logic             last_out,
    output logic             sticky
);

    shift_state_e     state_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   cnt_q;
    logic             mode_q;
    logic             lo_q;
    logic             st_q;
    logic [WIDTH-1:0] x_q;
    logic             busy_q;
    logic             done_q;
    logic             last_q;
    logic             sticky_q;

    // One-step shift of the working register; the sign bit is re-copied
    // each step so the captured sign persists through the whole operation.
    logic             fill_d;
    logic [WIDTH-1:0] data_d;

    assign fill_d = (mode_q == SH_ARITH) ? data_q[WIDTH-1] : 1'b0;
    assign data_d = {fill_d, data_q[WIDTH-1:1]};

    // Control FSM plus datapath; all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= SH_LOGICAL;
            lo_q     <= 1'b0;
            st_q     <= 1'b0;
            x_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        data_q  <= I;
                        cnt_q   <= Shift;
                        mode_q  <= arith;
                        lo_q    <= 1'b0;
                        st_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (Shift != '0) ? S_SHIFT : S_DONE;
                    end
                end
                S_SHIFT: begin
                    lo_q   <= data_q[0];
                    st_q   <= st_q | data_q[0];
                    data_q <= data_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    x_q      <= data_q;
                    last_q   <= lo_q;
                    sticky_q <= st_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign X        = x_q;
    assign last_out = last_q;
    assign sticky   = sticky_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter: latency, fill modes, sticky/last-out,
// ignored start while busy, async abort and back-to-back operation.
module tb_seq_right_shifter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] I = '0;
    logic [2:0] Shift = '0;
    logic       arith = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] X;
    logic       last_out;
    logic       sticky;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_right_shifter #(.WIDTH(8), .SHW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .I        (I),
        .Shift    (Shift),
        .arith    (arith),
        .busy     (busy),
        .done     (done),
        .X        (X),
        .last_out (last_out),
        .sticky   (sticky)
    );

    // Present operands for one edge; returns at accept edge + 1.
    task automatic accept(input logic [7:0] d, input logic [2:0] s, input logic a);
        start = 1'b1; I = d; Shift = s; arith = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done (n = -1 on timeout) and busy-high samples.
    task automatic wait_done(output int n, output int bc);
        bit seen;
        n = -1; bc = 0; seen = 0;
        if (busy) bc++;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n = k; seen = 1;
            end else if (busy) begin
                bc++;
            end
        end
    endtask

    task automatic check_res(input string nm, input logic [7:0] ex, input logic el, input logic es);
        tests++;
        if (X !== ex || last_out !== el || sticky !== es) begin
            fails++;
            $display("FAIL %s: X=%h last=%b sticky=%b, expected X=%h last=%b sticky=%b",
                     nm, X, last_out, sticky, ex, el, es);
        end else
            $display("[TB] %s: X=%h last=%b sticky=%b ok", nm, X, last_out, sticky);
    endtask

    task automatic check_lat(input string nm, input int n, input int ex);
        tests++;
        if (n !== ex) begin
            fails++;
            $display("FAIL %s latency: got %0d, expected %0d", nm, n, ex);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({busy, done, X, last_out, sticky} !== 12'h0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b X=%h last=%b sticky=%b, expected all 0",
                     busy, done, X, last_out, sticky);
        end else
            $display("[TB] reset: outputs 0 ok");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_logical();
        int n, bc;
        accept(8'b10110110, 3'd3, 1'b0);
        wait_done(n, bc);
        check_lat("logical3", n, 4);
        tests++;
        if (bc !== 4) begin
            fails++;
            $display("FAIL logical3 busy: %0d cycles, expected 4", bc);
        end
        check_res("logical3", 8'b00010110, 1'b1, 1'b1);
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_max_shift();
        int n, bc;
        accept(8'b11111010, 3'd7, 1'b1);
        wait_done(n, bc);
        check_lat("arith7", n, 8);
        check_res("arith7", 8'b11111111, 1'b1, 1'b1);
        accept(8'b11111010, 3'd7, 1'b0);
        wait_done(n, bc);
        check_lat("logical7", n, 8);
        check_res("logical7", 8'b00000001, 1'b1, 1'b1);
    endtask

    task automatic test_zero_shift();
        int n, bc;
        accept(8'h4D, 3'd0, 1'b1);
        wait_done(n, bc);
        check_lat("shift0", n, 1);
        check_res("shift0", 8'h4D, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        int dones;
        accept(8'h80, 3'd2, 1'b0);
        start = 1'b1; I = 8'hFF; Shift = 3'd1; arith = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (X !== 8'h4D) begin
            fails++;
            $display("FAIL hold_X: X=%h mid-op, expected 4d", X);
        end
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) dones++;
            if (done) check_res("ignore_start", 8'h20, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        tests++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL ignore_start dones: %0d, expected 1", dones);
        end
    endtask

    task automatic test_abort();
        int n, bc, dones;
        accept(8'hF0, 3'd5, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, X, last_out, sticky} !== 12'h0) begin
            fails++;
            $display("FAIL abort: busy=%b done=%b X=%h last=%b sticky=%b, expected all 0",
                     busy, done, X, last_out, sticky);
        end else
            $display("[TB] abort: outputs cleared ok");
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL abort_no_done: %0d active cycles, expected 0", dones);
        end
        accept(8'hF0, 3'd4, 1'b0);
        wait_done(n, bc);
        check_lat("after_abort", n, 5);
        check_res("after_abort", 8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n, bc;
        accept(8'h03, 3'd1, 1'b0);
        wait_done(n, bc);
        check_lat("b2b_first", n, 2);
        check_res("b2b_first", 8'h01, 1'b1, 1'b1);
        accept(8'h08, 3'd3, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b, expected 1", busy);
        end
        wait_done(n, bc);
        check_lat("b2b_second", n, 4);
        check_res("b2b_second", 8'h01, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_logical();
        test_max_shift();
        test_zero_shift();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
